// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide controller with the architectural HI/LO registers.
// Results are computed at launch; the counter models the fixed pipeline latency.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   phi, plo;
  logic          pdz;
  logic          done;

  logic is_mul, is_div, sgn, launch;
  assign is_mul = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
  assign is_div = (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
  assign sgn    = (MDOp == OP_MULT) || (MDOp == OP_DIV);
  assign launch = (state == IDLE) && Start && (is_mul || is_div);

  // One 64-bit multiplier serves both flavours: the low 64 bits of the
  // product of the extended operands are correct for signed and unsigned.
  logic [63:0] mul_a, mul_b, prod;
  assign mul_a = sgn ? {{32{A[31]}}, A} : {32'b0, A};
  assign mul_b = sgn ? {{32{B[31]}}, B} : {32'b0, B};
  assign prod  = mul_a * mul_b;

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 without a special case.
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;
  assign a_neg  = sgn & A[31];
  assign b_neg  = sgn & B[31];
  assign b_zero = (B == 32'd0);
  assign a_mag  = a_neg ? (32'd0 - A) : A;
  assign b_mag  = b_neg ? (32'd0 - B) : B;
  assign b_div  = b_zero ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_div;
  assign r_mag  = a_mag % b_div;
  assign quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          cnt_nxt   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          state_nxt = RUN;
        end
      end
      RUN: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign Busy = (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      phi   <= '0;
      plo   <= '0;
      pdz   <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (launch) begin
        phi <= is_mul ? prod[63:32] : rem;
        plo <= is_mul ? prod[31:0]  : quo;
        pdz <= is_div && b_zero;
      end
      // Commit and moves-to are exclusive: commit only happens out of RUN.
      if (done && !pdz) begin
        HI <= phi;
        LO <= plo;
      end else if (state == IDLE) begin
        if (MDOp == OP_MTHI) HI <= A;
        if (MDOp == OP_MTLO) LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, arithmetic, ignore-while-busy, reset.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch op, scramble inputs while running, check Busy for n cycles then results.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] ehi, input logic [31:0] elo);
    Start = 1'b1; MDOp = op; A = a; B = b;
    step();
    Start = 1'b0; MDOp = 3'd0;
    for (int i = 0; i < n; i++) begin
      A = $urandom; B = $urandom;
      chk({tag, "_busy"}, {31'b0, Busy}, 32'd1);
      step();
    end
    chk({tag, "_idle"}, {31'b0, Busy}, 32'd0);
    chk({tag, "_hi"}, HI, ehi);
    chk({tag, "_lo"}, LO, elo);
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; MDOp = 3'd0; A = '0; B = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);

    run_op("mult",  3'd1, 32'hFFFFFFFF, 32'h2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'h2, 5, 32'h00000001, 32'hFFFFFFFE);
    run_op("div",   3'd3, 32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",  3'd4, 32'hFFFFFFF9, 32'h2, 10, 32'h00000001, 32'h7FFFFFFC);
    run_op("div_nd", 3'd3, 32'h7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);

    // mtlo, then divide by zero leaves HI/LO untouched.
    MDOp = 3'd6; A = 32'h1234;
    step();
    MDOp = 3'd0;
    chk("mtlo_lo", LO, 32'h1234);
    chk("mtlo_busy", {31'b0, Busy}, 32'd0);
    run_op("divz", 3'd4, 32'h5, 32'h0, 10, 32'h0, 32'h1234);

    // mthi with Start asserted: writes, no launch.
    Start = 1'b1; MDOp = 3'd5; A = 32'hBEEF;
    step();
    Start = 1'b0; MDOp = 3'd0;
    chk("mthi_hi", HI, 32'hBEEF);
    chk("mthi_busy", {31'b0, Busy}, 32'd0);

    // Reserved op with Start: nothing happens.
    Start = 1'b1; MDOp = 3'd7; A = 32'h1; B = 32'h1;
    step();
    Start = 1'b0; MDOp = 3'd0;
    chk("rsv_busy", {31'b0, Busy}, 32'd0);
    chk("rsv_hi", HI, 32'hBEEF);
    chk("rsv_lo", LO, 32'h1234);

    // mult 3*4 with a div launch and mthi attempted mid-flight.
    Start = 1'b1; MDOp = 3'd1; A = 32'd3; B = 32'd4;
    step();
    Start = 1'b0; MDOp = 3'd0;
    chk("ign_b1", {31'b0, Busy}, 32'd1);
    step();
    chk("ign_b2", {31'b0, Busy}, 32'd1);
    Start = 1'b1; MDOp = 3'd3; A = 32'd100; B = 32'd3;
    step();
    chk("ign_b3", {31'b0, Busy}, 32'd1);
    Start = 1'b0; MDOp = 3'd5; A = 32'hDEAD;
    step();
    MDOp = 3'd0;
    chk("ign_b4", {31'b0, Busy}, 32'd1);
    chk("ign_hi_mid", HI, 32'hBEEF);
    step();
    chk("ign_b5", {31'b0, Busy}, 32'd1);
    step();
    chk("ign_idle", {31'b0, Busy}, 32'd0);
    chk("ign_hi", HI, 32'h0);
    chk("ign_lo", LO, 32'hC);
    step();
    chk("ign_stay", {31'b0, Busy}, 32'd0);

    // Reset mid-divide discards the result.
    Start = 1'b1; MDOp = 3'd3; A = 32'd100; B = 32'd7;
    step();
    Start = 1'b0; MDOp = 3'd0;
    step(); step();
    chk("rr_busy3", {31'b0, Busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr_busy", {31'b0, Busy}, 32'd0);
    chk("rr_hi", HI, 32'h0);
    chk("rr_lo", LO, 32'h0);
    for (int i = 0; i < 12; i++) step();
    chk("rr_late_busy", {31'b0, Busy}, 32'd0);
    chk("rr_late_hi", HI, 32'h0);
    chk("rr_late_lo", LO, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
